// File: rtl/ctrlpid_mc.sv
// rtl/ctrlpid_mc.sv - time-multiplexed multi-channel incremental PID controller
module ctrlpid_mc #(
  parameter int psc        = 10,
  parameter int aw         = 2,
  parameter int ew         = 24,
  parameter int pw         = 32,
  parameter int cw         = 6,
  parameter int ow         = 12,
  parameter int precision  = 1,
  parameter int fp         = 26 - psc,
  parameter int antiwindup = 255 << (precision + ow - 9)
) (
  input  logic                   clk_pid,
  input  logic                   reset_n,
  output logic [aw-1:0]          a,
  input  logic signed [ew-1:0]   error,
  input  logic signed [cw-1:0]   KP,
  input  logic signed [cw-1:0]   KI,
  input  logic signed [cw-1:0]   KD,
  input  logic [(1<<aw)-1:0]     en,
  input  logic [(1<<aw)-1:0]     clr,
  output logic signed [ow-1:0]   m_k_out,
  output logic [aw-1:0]          out_ch,
  output logic                   m_k_valid,
  output logic                   sat
);

  localparam int an = 1 << aw;
  localparam int sw = cw + 3;        // shift-amount width, wide enough that sums never wrap
  localparam int xw = pw + 2;        // update arithmetic width
  localparam int ww = 2 * pw + 2;    // shifter width, holds any left shift of an xw operand
  localparam int lw = psc - aw - 4;  // sub-step bits; a step fires when they are all zero

  localparam logic [3:0] ST_NOP   = 4'd0;
  localparam logic [3:0] ST_LOAD  = 4'd1;
  localparam logic [3:0] ST_P     = 4'd2;
  localparam logic [3:0] ST_D     = 4'd3;
  localparam logic [3:0] ST_I     = 4'd4;
  localparam logic [3:0] ST_D1    = 4'd5;
  localparam logic [3:0] ST_CLAMP = 4'd6;
  localparam logic [3:0] ST_OUT   = 4'd7;

  localparam logic signed [pw-1:0] wind  = pw'(antiwindup);
  localparam logic signed [ww-1:0] t_hi  = {{(ww-pw){1'b0}}, {pw{1'b1}}};
  localparam logic signed [ww-1:0] t_lo  = {{(ww-pw){1'b1}}, {pw{1'b0}}};
  localparam logic signed [xw-1:0] u_hi  = {3'b000, {(pw-1){1'b1}}};
  localparam logic signed [xw-1:0] u_lo  = {3'b111, {(pw-1){1'b0}}};

  logic [psc-1:0]         uswitch;
  logic [3:0]             step;
  logic                   tick;
  logic [an-1:0][pw-1:0]  e0_r, e1_r, e2_r, u_r;
  logic [an-1:0]          pending;
  logic                   clamp_flag;

  logic signed [pw-1:0]   e0_a, e1_a, e2_a, u_a, u_next;
  logic signed [sw-1:0]   kp_s, ki_s, kd_s, sh;
  logic signed [xw-1:0]   opnd, term, acc;
  logic                   sub;
  logic                   clamp_hi, clamp_lo;

  // Shift by a signed amount; the result is limited to pw+1 signed bits so the later add cannot wrap
  function automatic logic signed [xw-1:0] shift_sat(input logic signed [xw-1:0] x,
                                                     input logic signed [sw-1:0] s);
    logic signed [ww-1:0] wide;
    logic [sw-1:0]        mag;
    wide = ww'(x);
    mag  = s[sw-1] ? -s : s;
    if (mag > sw'(pw - 1)) mag = sw'(pw - 1);
    wide = s[sw-1] ? (wide >>> mag) : (wide <<< mag);
    if (wide > t_hi) wide = t_hi;
    else if (wide < t_lo) wide = t_lo;
    return wide[xw-1:0];
  endfunction

  // Saturate an update result into the signed accumulator range
  function automatic logic signed [pw-1:0] sat_pw(input logic signed [xw-1:0] v);
    logic signed [xw-1:0] r;
    r = v;
    if (v > u_hi) r = u_hi;
    else if (v < u_lo) r = u_lo;
    return r[pw-1:0];
  endfunction

  assign a    = uswitch[psc-1 -: aw];
  assign step = uswitch[psc-aw-1 -: 4];
  assign tick = (uswitch[lw-1:0] == '0);

  assign e0_a = e0_r[a];
  assign e1_a = e1_r[a];
  assign e2_a = e2_r[a];
  assign u_a  = u_r[a];

  assign kp_s = sw'(KP) + sw'(precision);
  assign ki_s = sw'(KI) + sw'(precision);
  assign kd_s = sw'(KD) + sw'(precision);

  assign clamp_hi = (u_a > wind);
  assign clamp_lo = (u_a < -wind);

  // Select the operand and shift of the current arithmetic step and form the saturated sum
  always_comb begin
    opnd = '0;
    sh   = '0;
    sub  = 1'b0;
    case (step)
      ST_P: begin
        opnd = xw'(e0_a) - xw'(e1_a);
        sh   = kp_s;
      end
      ST_D: begin
        opnd = xw'(e0_a) + xw'(e2_a);
        sh   = kd_s + sw'(fp);
      end
      ST_I: begin
        opnd = xw'(e0_a) + xw'(e1_a);
        sh   = ki_s - sw'(fp + 1);
      end
      ST_D1: begin
        opnd = xw'(e1_a);
        sh   = kd_s + sw'(fp + 1);
        sub  = 1'b1;
      end
      default: ;
    endcase
    term   = shift_sat(opnd, sh);
    acc    = sub ? (xw'(u_a) - term) : (xw'(u_a) + term);
    u_next = sat_pw(acc);
  end

  // Step sequencer, per-channel state, clear queue and registered output
  always_ff @(posedge clk_pid or negedge reset_n) begin
    if (!reset_n) begin
      uswitch    <= '0;
      e0_r       <= '0;
      e1_r       <= '0;
      e2_r       <= '0;
      u_r        <= '0;
      pending    <= '0;
      clamp_flag <= 1'b0;
      m_k_out    <= '0;
      out_ch     <= '0;
      m_k_valid  <= 1'b0;
      sat        <= 1'b0;
    end else begin
      uswitch   <= uswitch + psc'(1);
      m_k_valid <= 1'b0;
      pending   <= pending | clr;
      if (tick) begin
        case (step)
          ST_NOP: ;
          ST_LOAD: begin
            if (en[a]) begin
              e0_r[a] <= pw'(error);
              if (pending[a]) begin
                e1_r[a] <= '0;
                e2_r[a] <= '0;
                u_r[a]  <= '0;
              end
            end
          end
          ST_P, ST_D, ST_I, ST_D1: begin
            if (en[a]) u_r[a] <= u_next;
          end
          ST_CLAMP: begin
            clamp_flag <= en[a] && (clamp_hi || clamp_lo);
            if (en[a] && clamp_hi) u_r[a] <= wind;
            else if (en[a] && clamp_lo) u_r[a] <= -wind;
          end
          ST_OUT: begin
            m_k_out    <= en[a] ? u_a[precision+ow-1:precision] : '0;
            out_ch     <= a;
            sat        <= en[a] && clamp_flag;
            m_k_valid  <= 1'b1;
            e2_r[a]    <= e1_r[a];
            e1_r[a]    <= e0_r[a];
            pending[a] <= clr[a];
          end
          default: ;
        endcase
      end
      // A disabled channel keeps its whole history at zero
      for (int i = 0; i < an; i++) begin
        if (!en[i]) begin
          e0_r[i] <= '0;
          e1_r[i] <= '0;
          e2_r[i] <= '0;
          u_r[i]  <= '0;
        end
      end
    end
  end

endmodule

// File: doc/ctrlpid_mc.md
CTRLPID_MC -- requirements
Module: ctrlpid_mc

Interface
REQ-001 Parameter psc, default 10: prescaler bits; one full pass over all channels takes 2^psc clocks.
REQ-002 Parameter aw, default 2: channel address width; an = 2^aw channels; aw <= psc-8.
REQ-003 Parameter ew, default 24: error width; ew < pw.
REQ-004 Parameter pw, default 32: accumulator width.
REQ-005 Parameter cw, default 6: coefficient width.
REQ-006 Parameter ow, default 12: output width.
REQ-007 Parameter precision, default 1: fixed-point fraction bits.
REQ-008 Parameter fp, default 26-psc: log2 of the loop frequency.
REQ-009 Parameter antiwindup, default 8'hFF << (precision+ow-9): integrator magnitude limit.
REQ-010 Port clk_pid, in, 1: the single clock; all state changes on its rising edge.
REQ-011 Port reset_n, in, 1: asynchronous, active-low reset.
REQ-012 Port a, out, aw: address of the channel being computed; drives external error and coefficient memories.
REQ-013 Port error, in, ew, signed: error of channel a.
REQ-014 Ports KP, KI, KD, in, cw each, signed: log2 gains of channel a.
REQ-015 Port en, in, an: per-channel enable.
REQ-016 Port clr, in, an: per-channel state-clear request, one-clock pulse or level.
REQ-017 Port m_k_out, out, ow, signed: registered output.
REQ-018 Port out_ch, out, aw: channel to which m_k_out belongs.
REQ-019 Port m_k_valid, out, 1: one-clock strobe; m_k_out and out_ch are valid.
REQ-020 Port sat, out, 1: the last output was clamped by antiwindup.

Function
REQ-021 A free-running psc-bit counter uswitch shall run as follows: a = uswitch[psc-1:psc-aw]; 16 steps per channel slot; one step executes when the low psc-aw-4 bits equal 0.
REQ-022 Steps shall be:
- 0: NOP.
- 1: LOAD, e0 <= sign-extended error.
- 2: u += (e0-e1)<<<Kp.
- 3: u += (e0+e2) shifted by Kd+fp.
- 4: u += (e0+e1) shifted by Ki-1-fp.
- 5: u -= e1 shifted by Kd+1+fp.
- 6: CLAMP.
- 7: OUT.
- 8-15: idle.
REQ-023 Coefficient sums Kp = KP+precision (likewise Ki, Kd) and the derived shift amounts shall be computed at cw+3 bits signed, with no wrap-around.
REQ-024 A positive shift shall be an arithmetic left shift; a negative shift shall be an arithmetic right shift by its magnitude; the magnitude shall saturate at pw-1.
REQ-025 Each step-2..5 update shall be computed at pw+2 bits and saturated to the signed pw-bit range before being written; the accumulator shall never wrap.
REQ-026 CLAMP shall set u to +antiwindup if u > antiwindup and to -antiwindup if u < -antiwindup, and shall latch the clamp event into a per-slot flag.
REQ-027 OUT shall do all of the following in one step:
- m_k_out <= u[precision+ow-1:precision];
- out_ch <= a;
- sat <= clamp flag;
- m_k_valid = 1 for exactly one clock;
- e2 <= e1, e1 <= e0.
REQ-028 Channel history and the clear queue:
- Each channel shall hold independent e0, e1, e2, u.
- clr[i]=1 shall set pending[i].
- At LOAD of channel i with pending[i]=1: e1, e2, u are zeroed before the step-2 update.
- pending[i] is cleared at OUT of channel i, except when clr[i]=1 in that same clock (set wins).
REQ-029 A channel with en[i]=0 shall hold e0, e1, e2 and u at 0. At its OUT it shall still pulse m_k_valid, with m_k_out=0 and sat=0.
REQ-030 Channel address wrap-around: after channel an-1, channel 0 follows with no gap slot.
REQ-031 Coefficients and error shall be sampled only at the step that uses them; changes at other times shall have no effect.

Reset
REQ-032 While reset_n=0, all of the following shall be 0: uswitch, every e0/e1/e2/u, pending, m_k_out, out_ch, m_k_valid, sat.
REQ-033 Reset asserted mid-slot shall abort the computation with no m_k_valid pulse; after release the sequence restarts at channel 0, step 0.

Verification
REQ-034 P-only: psc=10, ch0, KP=2, KI=-31, KD=-31, error=10 constant -> first ch0 output 40, following ch0 outputs 40, sat=0.
REQ-035 I-only: KP=-31, KI=16, KD=-31, error=10 -> ch0 outputs 5, 15, 25; clr[0] pulsed -> next output 5.
REQ-036 Antiwindup: KP=5, KI=KD=-31, error=1000 -> m_k_out=2040, sat=1; error=-1000 after clr -> m_k_out=-2040, sat=1.
REQ-037 Scan and enable: all channels enabled except en[1]=0 with error 10 -> m_k_valid pulses with out_ch 0,1,2,3,0 at 256-clock spacing; ch1 m_k_out=0.
REQ-038 Reset mid-slot: reset_n low during step 4 of ch2 -> all outputs 0 immediately, no strobe; after release the first strobe is out_ch=0, with the ch0 value equal to a fresh first iteration.
